// File: rtl/du_pkg.sv
// du_pkg: shared constants, stage payload types and normalisation helpers for du_pipe
package du_pkg;
  localparam int DW = 64;
  localparam int DQ = 16;
  localparam logic [DW-1:0] ONE_Q = DW'(1) << DQ;
  localparam logic signed [DW-1:0] ZERO_EXP_DEF = -(64'sd8 <<< DQ);
  localparam logic [DW-1:0] EXP_MAX = {1'b0, {(DW-1){1'b1}}};
  typedef struct packed {
    logic [DW-1:0] fa;
    logic [DW-1:0] da;
    logic          fz;
    logic          dz;
    logic          sf;
    logic          sd;
  } s1_t;
  typedef struct packed {
    logic [DW-1:0] m_f;
    logic [DW-1:0] s_f;
    logic [DW-1:0] m_d;
    logic [DW-1:0] s_d;
    logic          fz;
    logic          dz;
    logic          sf;
    logic          sd;
  } s2_t;
  function automatic logic [DW-1:0] norm_m(input logic [DW-1:0] x, input int p, input logic found, input int q);
    return found ? (p > q ? x >> (p - q) : x << (q - p)) : '0;
  endfunction
  function automatic logic [DW-1:0] norm_s(input int p, input logic found, input int q);
    return found ? DW'(p - q) << q : '0;
  endfunction
endpackage

// File: rtl/du_pipe_lod.sv
// du_pipe_lod: leading-one detector returning the highest set bit position
module du_pipe_lod #(
  parameter int W = 64,
  parameter int PW = $clog2(W)
) (
  input  logic [W-1:0]  data_in,
  output logic [PW-1:0] lod_pos,
  output logic          found
);
  // Scan upward so the last hit is the most significant set bit
  always_comb begin
    lod_pos = '0;
    found = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (data_in[i]) begin
        lod_pos = PW'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/du_pipe.sv
// du_pipe: 3-stage per-lane log2-domain divider F / (1 + s_xi) with shared valid/ready
module du_pipe import du_pkg::*; #(
  parameter int W = DW,
  parameter int Q = DQ,
  parameter int LANES = 4,
  parameter logic signed [W-1:0] ZERO_EXP = ZERO_EXP_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES-1:0][W-1:0]   in_f,
  input  logic [LANES-1:0][W-1:0]   in_sxi,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES-1:0][W-1:0]   out_exp,
  output logic [LANES-1:0]          out_sign,
  output logic [LANES-1:0]          out_dz
);
  localparam int PW = $clog2(W);
  localparam logic [W-1:0] ONE = W'(ONE_Q >> DQ) << Q;
  logic v1, v2, advance;
  assign advance = !out_valid || out_ready;
  assign in_ready = advance;
  // Valid bits shift as one unit whenever the output slot can move
  always_ff @(posedge clk) begin
    if (!rst_n) {v1, v2, out_valid} <= '0;
    else if (advance) {v1, v2, out_valid} <= {in_valid, v1, v2};
  end
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [W-1:0] f, d, e, exp_q;
    logic [PW-1:0] pf, pd;
    logic ff, fd, sign_q, dz_q;
    s1_t s1_n, s1_q;
    s2_t s2_n, s2_q;
    assign f = in_f[l];
    assign d = in_sxi[l] + ONE;
    assign s1_n = '{fa: f[W-1] ? -f : f, da: d[W-1] ? -d : d, fz: f == '0, dz: d == '0, sf: f[W-1], sd: d[W-1]};
    du_pipe_lod #(.W(W)) u_lod_f (.data_in(s1_q.fa), .lod_pos(pf), .found(ff));
    du_pipe_lod #(.W(W)) u_lod_d (.data_in(s1_q.da), .lod_pos(pd), .found(fd));
    assign s2_n = '{m_f: norm_m(s1_q.fa, int'(pf), ff, Q), s_f: norm_s(int'(pf), ff, Q),
                    m_d: norm_m(s1_q.da, int'(pd), fd, Q), s_d: norm_s(int'(pd), fd, Q),
                    fz: s1_q.fz, dz: s1_q.dz, sf: s1_q.sf, sd: s1_q.sd};
    assign e = (s2_q.m_f + s2_q.s_f) - (s2_q.m_d + s2_q.s_d);
    // Stage payloads and override-resolved results, all frozen while stalled
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1_q <= '0;
        s2_q <= '0;
        exp_q <= '0;
        sign_q <= 1'b0;
        dz_q <= 1'b0;
      end else if (advance) begin
        s1_q <= s1_n;
        s2_q <= s2_n;
        exp_q <= s2_q.fz ? ZERO_EXP : s2_q.dz ? EXP_MAX : e;
        sign_q <= !s2_q.fz && (s2_q.dz ? s2_q.sf : s2_q.sf ^ s2_q.sd);
        dz_q <= s2_q.dz;
      end
    end
    assign out_exp[l] = exp_q;
    assign out_sign[l] = sign_q;
    assign out_dz[l] = dz_q;
  end
endmodule

// File: tb/tb_du_pipe.sv
// tb_du_pipe: directed and randomized checks of du_pipe against a scoreboard model
module tb_du_pipe;
  localparam int W = 64, Q = 16, L = 4;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [L-1:0][W-1:0] in_f = '0, in_sxi = '0, out_exp;
  logic [L-1:0] out_sign, out_dz;
  typedef struct packed {
    logic [L-1:0][W-1:0] e;
    logic [L-1:0]        s;
    logic [L-1:0]        z;
  } beat_t;
  beat_t q[$];
  beat_t held;
  bit stall_prev = 1'b0, acc = 1'b0, saw_block;
  int tests = 0, fails = 0, lat, sent, stall_cnt, n, ghost;

  du_pipe dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_f(in_f),
               .in_sxi(in_sxi), .out_valid(out_valid), .out_ready(out_ready), .out_exp(out_exp),
               .out_sign(out_sign), .out_dz(out_dz));

  always #5 clk = ~clk;

  // log2(x) + 1 in Q format: integer part from the top set bit, fraction from the bits below it
  function automatic logic [W-1:0] g(input logic [W-1:0] x);
    int p;
    logic [127:0] w;
    if (x == '0) return '0;
    p = 0;
    while ((x >> (p + 1)) != '0) p++;
    w = ({64'd0, x} << Q) >> p;
    return w[63:0] + 64'((longint'(p) - Q) * (longint'(1) << Q));
  endfunction

  function automatic beat_t model(input logic [L-1:0][W-1:0] f, input logic [L-1:0][W-1:0] x);
    beat_t b;
    logic [W-1:0] d, fa, da;
    for (int l = 0; l < L; l++) begin
      d = x[l] + (64'd1 << Q);
      fa = f[l][W-1] ? -f[l] : f[l];
      da = d[W-1] ? -d : d;
      if (f[l] == '0) begin
        b.e[l] = -(64'd8 << Q); b.s[l] = 1'b0; b.z[l] = (d == '0);
      end else if (d == '0) begin
        b.e[l] = {1'b0, {63{1'b1}}}; b.s[l] = f[l][W-1]; b.z[l] = 1'b1;
      end else begin
        b.e[l] = g(fa) - g(da); b.s[l] = f[l][W-1] ^ d[W-1]; b.z[l] = 1'b0;
      end
    end
    return b;
  endfunction

  function automatic logic [W-1:0] rnd_f();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return {$urandom, $urandom};
      2: return 64'($urandom_range(1, 1 << 22));
      3: return -64'($urandom_range(1, 1 << 22));
      default: return 64'd1 << $urandom_range(0, 62);
    endcase
  endfunction

  function automatic logic [W-1:0] rnd_sxi();
    case ($urandom_range(0, 4))
      0: return -(64'd1 << Q);
      1: return {$urandom, $urandom};
      2: return 64'($urandom_range(0, 1 << 20));
      3: return -64'($urandom_range(1, 1 << 17));
      default: return 64'd1 << $urandom_range(0, 62);
    endcase
  endfunction

  task automatic set_rand();
    for (int l = 0; l < L; l++) begin
      in_f[l] = rnd_f();
      in_sxi[l] = rnd_sxi();
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input beat_t b);
    for (int l = 0; l < L; l++) begin
      chk($sformatf("%s.exp[%0d]", tag, l), out_exp[l], b.e[l]);
      chk($sformatf("%s.sign[%0d]", tag, l), 64'(out_sign[l]), 64'(b.s[l]));
      chk($sformatf("%s.dz[%0d]", tag, l), 64'(out_dz[l]), 64'(b.z[l]));
    end
  endtask

  // One cycle: called just after a negedge with inputs already driven
  task automatic tick();
    #1;
    if (stall_prev) begin
      chk("stall.valid", 64'(out_valid), 64'd1);
      chk_beat("stall", held);
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
      else chk_beat("result", q.pop_front());
    end
    held = '{e: out_exp, s: out_sign, z: out_dz};
    stall_prev = rst_n && out_valid && !out_ready;
    acc = rst_n && in_valid && in_ready;
    if (acc) q.push_back(model(in_f, in_sxi));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(output int l);
    l = 1;
    while (!out_valid && l < 10) begin
      l++;
      tick();
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, 64'(out_valid), 64'd0);
    for (int l = 0; l < L; l++) chk($sformatf("%s.exp[%0d]", tag, l), out_exp[l], 64'd0);
    chk({tag, ".sign"}, 64'(out_sign), 64'd0);
    chk({tag, ".dz"}, 64'(out_dz), 64'd0);
  endtask

  initial begin
    @(negedge clk);
    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    // in_sxi carries exp(s_xi), so s_xi = 0 is driven as 1.0 (0x10000)
    set_rand();
    in_f[0] = 64'h10000;  in_sxi[0] = 64'h10000;
    in_f[1] = -64'h30000; in_sxi[1] = 64'h10000;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("a.accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
    wait_valid(lat);
    chk("a.latency", 64'(lat), 64'd3);
    chk("a.exp0", out_exp[0], 64'hFFFF_FFFF_FFFF_0000);
    chk("a.sign0", 64'(out_sign[0]), 64'd0);
    chk("a.dz0", 64'(out_dz[0]), 64'd0);
    chk("a.exp1", out_exp[1], 64'h8000);
    chk("a.sign1", 64'(out_sign[1]), 64'd1);
    chk("a.dz1", 64'(out_dz[1]), 64'd0);
    tick();
    set_rand();
    in_f[0] = '0;         in_sxi[0] = 64'h10000;
    in_f[1] = 64'h10000;  in_sxi[1] = -64'h10000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    chk("b.latency", 64'(lat), 64'd3);
    chk("b.exp0", out_exp[0], 64'hFFFF_FFFF_FFF8_0000);
    chk("b.sign0", 64'(out_sign[0]), 64'd0);
    chk("b.dz0", 64'(out_dz[0]), 64'd0);
    chk("b.exp1", out_exp[1], 64'h7FFF_FFFF_FFFF_FFFF);
    chk("b.dz1", 64'(out_dz[1]), 64'd1);
    tick();
    sent = 0; stall_cnt = 0; saw_block = 1'b0; n = 0;
    while ((sent < 6 || q.size() > 0) && n < 60) begin
      n++;
      in_valid = (sent < 6);
      set_rand();
      out_ready = !(out_valid && stall_cnt < 5);
      if (out_valid && stall_cnt < 5) stall_cnt++;
      tick();
      if (acc) sent++;
      else if (in_valid) saw_block = 1'b1;
    end
    in_valid = 1'b0;
    chk("stream.sent", 64'(sent), 64'd6);
    chk("stream.drained", 64'(q.size()), 64'd0);
    chk("stream.stall_cycles", 64'(stall_cnt), 64'd5);
    chk("stream.in_ready_low", 64'(saw_block), 64'd1);
    repeat (400) begin
      in_valid = 1'($urandom_range(0, 1));
      set_rand();
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      n++;
      tick();
    end
    chk("random.drained", 64'(q.size()), 64'd0);
    in_valid = 1'b1;
    repeat (3) begin
      set_rand();
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    q.delete();
    chk_zero("midreset");
    rst_n = 1'b1;
    chk("midreset.in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    ghost = 0;
    repeat (8) begin
      if (out_valid) ghost++;
      tick();
    end
    chk("midreset.no_ghost", 64'(ghost), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/du_pipe.md
DU_PIPE -- requirements
Module: du_pipe

Interface
REQ-001 Parameter W, default 64, data width of every operand and result.
REQ-002 Parameter Q, default 16, fractional bits (QW-Q.Q fixed point).
REQ-003 Parameter LANES, default 4, number of independent division lanes sharing one handshake.
REQ-004 Parameter ZERO_EXP, default -8.0 in Q format (-524288 for Q=16), exponent emitted when the numerator is zero.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset; synchronous and active-low.
REQ-007 in_valid  input  1  all lanes of in_f/in_sxi are valid.
REQ-008 in_ready  output  1  block accepts the input beat this cycle.
REQ-009 in_f  input  LANES x W signed  numerator F per lane.
REQ-010 in_sxi  input  LANES x W signed  exp(s_xi) per lane, from the EU.
REQ-011 out_valid  output  1  result beat valid.
REQ-012 out_ready  input  1  downstream accepts the result beat.
REQ-013 out_exp  output  LANES x W signed  log2-domain exponent per lane.
REQ-014 out_sign  output  LANES x 1  result sign per lane.
REQ-015 out_dz  output  LANES x 1  divide-by-zero flag per lane (1 + s_xi == 0).

Function
REQ-016 The block computes, per lane, F / (1 + s_xi) in log2 form over a 3-stage pipeline: S1 (denominator, abs, zero detect), S2 (LOD, normalise), S3 (exponent sum, override).
REQ-017 S1: D = ONE_Q + s_xi (mod 2^W); Fa = |F|; Da = |D|; fz = (F == 0); dz = (D == 0); sF = F[W-1]; sD = D[W-1].
REQ-018 S2: for X in {Fa, Da} with leading-one position p: s = (p - Q) << Q; m = X >> (p - Q) if p > Q, X << (Q - p) if p < Q, else X; m = s = 0 when X == 0.
REQ-019 S3: exp = (m1 + s1) - (m2 + s2), W-bit two's-complement wrap; sign = sF ^ sD.
REQ-020 S3 override priority: fz -> exp = ZERO_EXP, sign 0, dz flag = dz; else dz -> exp = max positive (2^(W-1) - 1), sign = sF, out_dz = 1.
REQ-021 Latency is exactly 3 cycles from an accepted input beat to out_valid with no backpressure; throughput is 1 beat/cycle.
REQ-022 Advance = !out_valid || out_ready; in_ready = advance; all stage registers and valid bits move only when advance = 1.
REQ-023 When advance = 0, every stage register holds; out_exp/out_sign/out_dz remain stable while out_valid = 1 and out_ready = 0.
REQ-024 Bubbles (invalid stages) propagate with advance; no beat is dropped or duplicated; in_valid while in_ready = 0 is ignored.
REQ-025 Lanes are fully independent in data; they share valid, ready and stall.

Reset
REQ-026 While rst_n = 0 at a clock edge: all stage valid bits, out_valid, out_exp, out_sign and out_dz are set to 0.
REQ-027 Reset asserted mid-operation discards all in-flight beats; in_ready = 1 on the first cycle after reset deasserts.

Structure
REQ-028 Package du_pkg holds ONE_Q, the default ZERO_EXP, the max-positive exponent constant and the per-lane stage struct typedefs (S1 and S2 payloads).
REQ-029 Leading-one detection reuses the existing LOD sub-module (ports data_in, lod_pos, found), two instances per lane, generated by lane loop.

Verification
REQ-030 F = 0x10000 (1.0), s_xi = 0 -> out_exp = -0x10000 (-1.0), sign 0, dz 0, out_valid exactly 3 cycles after acceptance.
REQ-031 F = -0x30000 (-3.0), s_xi = 0 -> out_exp = 0x8000 (0.5), sign 1, dz 0.
REQ-032 F = 0, s_xi = 0x10000 -> out_exp = 0xFFFF_FFFF_FFF8_0000 (-8.0), sign 0; F = 0x10000, s_xi = -0x10000 -> out_exp = 0x7FFF_FFFF_FFFF_FFFF, out_dz = 1.
REQ-033 Stream 6 back-to-back beats, out_ready low for 5 cycles from the first result -> in_ready low after pipe fills, results emerge in order, none lost/duplicated, outputs stable while stalled.
REQ-034 Different vectors on each of 4 lanes in one beat -> each lane matches a per-lane reference model independently.
REQ-035 rst_n low for 1 cycle with 3 beats in flight -> out_valid = 0 and all outputs 0 next cycle; no pre-reset beat appears afterwards.
